// File: rtl/riscv_mul_seq_pkg.sv
// rtl/riscv_mul_seq_pkg.sv - shared ALU opcodes used by the multiply sequencer
package riscv_mul_seq_pkg;

  // Mirrors the ALU_ADD encoding of the shared integer ALU.
  localparam logic [3:0] ALU_ADD = 4'd0;

endpackage

// File: rtl/riscv_mul_seq.sv
// rtl/riscv_mul_seq.sv - iterative RV64M MUL sequencer borrowing the shared EX ALU for its adds
module riscv_mul_seq
  import riscv_mul_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            alu_req_o,
  input  logic            alu_gnt_i,
  output logic [3:0]      alu_control_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ADD   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;

  assign req_ready_o   = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign alu_req_o     = (state == ADD);
  assign alu_control_o = ALU_ADD;
  assign alu_a_o       = acc;
  assign alu_b_o       = mcand;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      result_o     <= '0;
      resp_valid_o <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      // A flush abandons any operation, including one about to respond.
      if (flush_i && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid_i && !flush_i) begin
              acc    <= '0;
              mcand  <= req_a_i;
              mplier <= req_b_i;
              state  <= CHECK;
            end
          end
          CHECK: begin
            if (mplier == '0) begin
              state <= DONE;
            end else if (mplier[0]) begin
              state <= ADD;
            end else begin
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
          ADD: begin
            if (alu_gnt_i) begin
              acc    <= alu_result_i;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              state  <= CHECK;
            end
          end
          DONE: begin
            result_o     <= acc;
            resp_valid_o <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
